// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
// Holds the FSM state type and register-address helpers.
package hazard_pkg;

  typedef enum logic {
    RUN,
    LU_STALL
  } hz_state_t;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (sync, active-low), inc, count.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and mispredict flush control for the ID stage.
// In: ID sources, EX load/rd, mispredict. Out: kill mux, enables, flushes, perf counts.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mispredict,
  output logic                  stall_mux_Sel,
  output logic                  pc_wr_en,
  output logic                  if_id_wr_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  hz_state_t  state_q;
  hz_state_t  state_d;
  logic [2:0] rem_q;
  logic [2:0] rem_d;
  logic       lu_hit;
  logic       rs1_hit;
  logic       rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
  assign lu_hit  = ex_mem_read && (ex_rd != REG_X0)
                && (rs1_hit || rs2_hit);

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    stall_mux_Sel = 1'b0;
    pc_wr_en      = 1'b1;
    if_id_wr_en   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
      rem_d   = '0;
    end else if (ex_mispredict) begin
      // Redirect wins over any stall, including one in progress.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = RUN;
      rem_d       = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu_hit) begin
            stall_mux_Sel = 1'b1;
            pc_wr_en      = 1'b0;
            if_id_wr_en   = 1'b0;
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              rem_d   = LAT_M1;
            end
          end
        end
        LU_STALL: begin
          stall_mux_Sel = 1'b1;
          pc_wr_en      = 1'b0;
          if_id_wr_en   = 1'b0;
          rem_d         = rem_q - 1'b1;
          if (rem_q == 3'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_mux_Sel),
    .count(stall_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (if_id_flush),
    .count(flush_count)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench: two DUTs (LOAD_LAT 1 and 3, narrow counters)
// share stimulus; expected outputs queued per cycle, checked at negedge.
module tb_hazard_detection_unit;

  typedef struct packed {
    logic        stall;
    logic        pc;
    logic        ifwr;
    logic        iffl;
    logic        exfl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       ex_mispredict = 1'b0;

  logic       sel0, pc0, ifwr0, iffl0, exfl0;
  logic [4:0] sc0, fc0;
  logic       sel1, pc1, ifwr1, iffl1, exfl1;
  logic [5:0] sc1, fc1;

  int compared = 0;
  int mismatched = 0;

  exp_t q0[$];
  exp_t q1[$];

  int bub[2];
  int scnt[2];
  int fcnt[2];
  int lat[2] = '{1, 3};
  int cmax[2] = '{31, 63};

  always #5 clk = ~clk;

  hazard_detection_unit #(
    .LOAD_LAT(1),
    .CNT_W   (5)
  ) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_mispredict(ex_mispredict),
    .stall_mux_Sel(sel0),
    .pc_wr_en     (pc0),
    .if_id_wr_en  (ifwr0),
    .if_id_flush  (iffl0),
    .id_ex_flush  (exfl0),
    .stall_count  (sc0),
    .flush_count  (fc0)
  );

  hazard_detection_unit #(
    .LOAD_LAT(3),
    .CNT_W   (6)
  ) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_mispredict(ex_mispredict),
    .stall_mux_Sel(sel1),
    .pc_wr_en     (pc1),
    .if_id_wr_en  (ifwr1),
    .if_id_flush  (iffl1),
    .id_ex_flush  (exfl1),
    .stall_count  (sc1),
    .flush_count  (fc1)
  );

  // Drive one cycle of inputs and queue what each DUT should show.
  task automatic step(input logic rn, input logic mr,
                      input logic mp, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2);
    logic hit;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    ex_mem_read = mr;
    ex_mispredict = mp;
    ex_rd = rd;
    id_rs1 = r1;
    id_rs2 = r2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    hit = mr && (rd != 0)
       && ((u1 && r1 == rd) || (u2 && r2 == rd));
    for (int d = 0; d < 2; d++) begin
      e = '0;
      e.pc = 1'b1;
      e.ifwr = 1'b1;
      e.sc = 32'(scnt[d]);
      e.fc = 32'(fcnt[d]);
      if (!rn) begin
        bub[d] = 0;
      end else if (mp) begin
        e.iffl = 1'b1;
        e.exfl = 1'b1;
        bub[d] = 0;
      end else if (bub[d] > 0 || hit) begin
        e.stall = 1'b1;
        e.pc = 1'b0;
        e.ifwr = 1'b0;
        bub[d] = (bub[d] > 0) ? bub[d] - 1 : lat[d] - 1;
      end
      if (!rn) begin
        scnt[d] = 0;
        fcnt[d] = 0;
      end else begin
        if (e.stall && scnt[d] < cmax[d]) scnt[d]++;
        if (e.iffl && fcnt[d] < cmax[d]) fcnt[d]++;
      end
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input int d, input exp_t a, input exp_t e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL dut%0d t=%0t got sel/pc/ifwr/iffl/exfl=%b%b%b%b%b sc=%0d fc=%0d exp %b%b%b%b%b sc=%0d fc=%0d",
               d, $time, a.stall, a.pc, a.ifwr, a.iffl, a.exfl,
               a.sc, a.fc, e.stall, e.pc, e.ifwr, e.iffl, e.exfl,
               e.sc, e.fc);
    end
  endtask

  always @(negedge clk) begin
    exp_t a;
    if (q0.size() > 0) begin
      a = {sel0, pc0, ifwr0, iffl0, exfl0, 32'(sc0), 32'(fc0)};
      check(0, a, q0.pop_front());
    end
    if (q1.size() > 0) begin
      a = {sel1, pc1, ifwr1, iffl1, exfl1, 32'(sc1), 32'(fc1)};
      check(1, a, q1.pop_front());
    end
  end

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    case ($urandom_range(0, 3))
      0: r = 5'd0;
      1: r = 5'd5;
      2: r = 5'd7;
      default: r = 5'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    logic [4:0] rd;
    logic [4:0] r1;
    logic [4:0] r2;
    for (int d = 0; d < 2; d++) begin
      bub[d] = 0;
      scnt[d] = 0;
      fcnt[d] = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // load x5, rs1=x5 used
    step(1, 1, 0, 5, 5, 0, 1, 0);
    idle();
    idle();
    idle();
    // x0 destination never hazards
    step(1, 1, 0, 0, 0, 0, 0, 1);
    // rs2 matches but unused
    step(1, 1, 0, 9, 0, 9, 0, 0);
    // load x7, rs2=x7, load drops after first cycle
    step(1, 1, 0, 7, 0, 7, 0, 1);
    idle();
    idle();
    idle();
    // hit and mispredict together
    step(1, 1, 1, 5, 5, 0, 1, 0);
    idle();
    // reset in the second cycle of a stall
    step(1, 1, 0, 7, 7, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    // back-to-back hazards and counter saturation
    repeat (70) step(1, 1, 0, 12, 12, 12, 1, 1);
    idle();
    repeat (70) step(1, 0, 1, 0, 0, 0, 0, 0);
    idle();
    repeat (1500) begin
      rd = pick_reg();
      r1 = ($urandom_range(0, 2) == 0) ? rd : pick_reg();
      r2 = ($urandom_range(0, 2) == 0) ? rd : pick_reg();
      step(($urandom_range(0, 40) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0),
           rd, r1, r2,
           1'($urandom), 1'($urandom));
    end
    idle();
    repeat (3) @(posedge clk);
    compared++;
    if (q0.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d/%0d left exp 0/0",
               q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
